// File: rtl/macro_seq_cntdn5_pkg.sv
// Shared definitions for the countdown sequencer: counter width and FSM state encodings.
package macro_seq_cntdn5_pkg;

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/macro_seq_cntdn5_decr5.sv
// 5-bit decrementer: q = d - 1 with wrap 0 -> 31; c flags the borrow (d == 0).
module macro_rom_decr5
  import macro_seq_cntdn5_pkg::*;
(
  input  logic [CNT_W-1:0] d_i,
  output logic [CNT_W-1:0] q_o,
  output logic             c_o
);

  assign c_o = (d_i == '0);
  assign q_o = d_i - CNT_W'(1);

endmodule

// File: rtl/macro_seq_cntdn5.sv
// Loadable countdown sequencer: accepts a step count, emits one step per cycle
// with the remaining index, then presents a done token over valid/ready.
module macro_seq_cntdn5
  import macro_seq_cntdn5_pkg::*;
#(
  parameter bit ZERO_IS_32 = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [CNT_W-1:0] s_count,
  input  logic             i_hold,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_step,
  output logic [CNT_W-1:0] o_index,
  output logic             o_last,
  output logic             m_valid,
  input  logic             m_ready
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dec_in, dec_q;
  logic             dec_c;

  // One decrementer serves both the load (from s_count) and every step (from cnt).
  assign dec_in = (state_q == ST_IDLE) ? s_count : cnt_q;

  macro_rom_decr5 u_decr5 (
    .d_i (dec_in),
    .q_o (dec_q),
    .c_o (dec_c)
  );

  assign o_busy = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_ready = 1'b0;
    o_step  = 1'b0;
    o_index = '0;
    o_last  = 1'b0;
    m_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          cnt_d   = dec_q;
          state_d = (dec_c && !ZERO_IS_32) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        o_index = cnt_q;
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (!i_hold) begin
          o_step = 1'b1;
          o_last = dec_c;
          cnt_d  = dec_q;
          if (dec_c) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        m_valid = 1'b1;
        if (i_abort || m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_macro_seq_cntdn5.sv
// Bench for macro_seq_cntdn5: both ZERO_IS_32 variants run the same stimulus against a
// remaining-steps reference model; directed scenarios first, then random traffic.
module tb_macro_seq_cntdn5;

  logic       clk = 1'b0;
  logic       reset, s_valid, i_hold, i_abort, m_ready;
  logic [4:0] s_count;

  logic       s_ready_a, o_busy_a, o_step_a, o_last_a, m_valid_a;
  logic [4:0] o_index_a;
  logic       s_ready_b, o_busy_b, o_step_b, o_last_b, m_valid_b;
  logic [4:0] o_index_b;

  int errors = 0;
  int checks = 0;

  // Model state per DUT: mode 0 idle, 1 stepping, 2 waiting for done handshake; -1 unknown.
  int m_mode [2];
  int m_rem  [2];
  int m_z    [2];

  always #5 clk = ~clk;

  macro_seq_cntdn5 #(.ZERO_IS_32(1'b1)) dut_a (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_a), .s_count(s_count),
    .i_hold(i_hold), .i_abort(i_abort), .o_busy(o_busy_a), .o_step(o_step_a),
    .o_index(o_index_a), .o_last(o_last_a), .m_valid(m_valid_a), .m_ready(m_ready)
  );

  macro_seq_cntdn5 #(.ZERO_IS_32(1'b0)) dut_b (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_b), .s_count(s_count),
    .i_hold(i_hold), .i_abort(i_abort), .o_busy(o_busy_b), .o_step(o_step_b),
    .o_index(o_index_b), .o_last(o_last_b), .m_valid(m_valid_b), .m_ready(m_ready)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_dut(input int k);
    logic [4:0] idx;
    logic       stp;
    logic       sr, bz, st, ls, mv;
    logic [4:0] ix;
    if (k == 0) begin
      sr = s_ready_a; bz = o_busy_a; st = o_step_a; ix = o_index_a; ls = o_last_a; mv = m_valid_a;
    end else begin
      sr = s_ready_b; bz = o_busy_b; st = o_step_b; ix = o_index_b; ls = o_last_b; mv = m_valid_b;
    end
    stp = (m_mode[k] == 1) && !i_hold && !i_abort;
    idx = (m_mode[k] == 1) ? 5'(m_rem[k] - 1) : 5'd0;
    chk_eq($sformatf("s_ready[%0d]", k), 32'(sr), 32'(m_mode[k] == 0));
    chk_eq($sformatf("o_busy[%0d]", k),  32'(bz), 32'(m_mode[k] != 0));
    chk_eq($sformatf("o_step[%0d]", k),  32'(st), 32'(stp));
    chk_eq($sformatf("o_index[%0d]", k), 32'(ix), 32'(idx));
    chk_eq($sformatf("o_last[%0d]", k),  32'(ls), 32'(stp && m_rem[k] == 1));
    chk_eq($sformatf("m_valid[%0d]", k), 32'(mv), 32'(m_mode[k] == 2));
  endtask

  task automatic model_update(input int k);
    int n;
    if (reset) begin
      m_mode[k] = 0;
      m_rem[k]  = 0;
    end else begin
      case (m_mode[k])
        0: if (s_valid) begin
          n = (s_count != 0) ? int'(s_count) : (m_z[k] != 0 ? 32 : 0);
          if (n == 0) m_mode[k] = 2;
          else begin
            m_mode[k] = 1;
            m_rem[k]  = n;
          end
        end
        1: if (i_abort) m_mode[k] = 0;
           else if (!i_hold) begin
             m_rem[k] = m_rem[k] - 1;
             if (m_rem[k] == 0) m_mode[k] = 2;
           end
        2: if (i_abort || m_ready) m_mode[k] = 0;
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input logic rst, input logic sv, input logic [4:0] cnt,
                       input logic h, input logic ab, input logic mr);
    @(posedge clk);
    #1;
    reset = rst; s_valid = sv; s_count = cnt; i_hold = h; i_abort = ab; m_ready = mr;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (m_mode[k] >= 0) check_dut(k);
      model_update(k);
    end
  endtask

  task automatic idle_n(input int n, input logic mr);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, mr);
  endtask

  initial begin
    m_mode = '{-1, -1};
    m_rem  = '{0, 0};
    m_z    = '{1, 0};
    reset = 1'b1; s_valid = 1'b0; s_count = '0; i_hold = 1'b0; i_abort = 1'b0; m_ready = 1'b0;

    cycle(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle_n(2, 1'b0);

    // basic count of 3, done held one extra cycle, then handshake
    cycle(1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    idle_n(4, 1'b0);
    idle_n(2, 1'b1);

    // count of 0: 32 steps on dut_a, immediate done on dut_b
    cycle(1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    idle_n(33, 1'b0);
    idle_n(2, 1'b1);

    // hold for 3 cycles while index is 5
    cycle(1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    idle_n(2, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    idle_n(7, 1'b0);
    idle_n(2, 1'b1);

    // abort when index is 5
    cycle(1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
    idle_n(4, 1'b0);
    cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    idle_n(3, 1'b0);

    // done stalled 4 cycles with s_valid pending, then handshake
    cycle(1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    idle_n(2, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // reset mid-run at index 12, then single-step sequence
    cycle(1'b0, 1'b1, 5'd20, 1'b0, 1'b0, 1'b0);
    idle_n(7, 1'b0);
    cycle(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    idle_n(3, 1'b1);

    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(199) == 0,
            $urandom_range(1),
            ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31)),
            $urandom_range(4) == 0,
            $urandom_range(39) == 0,
            $urandom_range(1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
